sram_wr_pattern_gen: RTL

//  Synthesizable SRAM write-stream generator: on a start pulse, waits a settle time, then writes
//  one or more frames of P_PIC_SIZE words into SRAM from P_START_ADDR. Data pattern is run-time

---
 rtl/sram_wr_pattern_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_wr_pattern_gen.sv
// rtl/sram_wr_pattern_gen.sv - SRAM write-stream generator: settle hold, backpressure, multi-frame runs, selectable data patterns
module sram_wr_pattern_gen #(
    parameter int              AW           = 8,
    parameter int              DW           = 128,
    parameter logic [AW-1:0]   P_START_ADDR = '0,
    parameter int              P_DATA_HOLD  = 9,
    parameter int              P_PIC_SIZE   = 256
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [3:0]    frames,
    input  logic          wr_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [3:0]    frame_idx
);
    localparam int              HW        = (P_DATA_HOLD > 1) ? $clog2(P_DATA_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'((P_DATA_HOLD > 0) ? P_DATA_HOLD - 1 : 0);
    localparam logic [AW-1:0]   PIC_LAST  = AW'(P_PIC_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_HOLD  = 4'b0010,
        S_WDATA = 4'b0100,
        S_STOP  = 4'b1000
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    frames_q, frames_d;
    logic [3:0]    frame_idx_q, frame_idx_d;
    logic [AW-1:0] beat_cnt_q, beat_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    pix_q, pix_d;
    logic [2:0]    bit_q, bit_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [AW-1:0] bc,
                                              input logic [3:0] fi, input logic [7:0] px,
                                              input logic [2:0] bt);
        logic [7:0] b;
        b = 8'(bc) + {4'b0000, fi};
        case (m)
            2'd0:    pattern = {(DW/8){b}};
            2'd1:    pattern = {DW{px[bt]}};
            2'd2:    pattern = {DW{1'b1}};
            default: pattern = {(DW/8){bc[0] ? 8'h55 : 8'hAA}};
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        frames_d    = frames_q;
        frame_idx_d = frame_idx_q;
        beat_cnt_d  = beat_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        pix_d       = pix_q;
        bit_d       = bit_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    frames_d    = (frames == 4'd0) ? 4'd1 : frames;
                    frame_idx_d = 4'd0;
                    beat_cnt_d  = '0;
                    hold_cnt_d  = '0;
                    pix_d       = 8'd0;
                    bit_d       = 3'd0;
                    state_d     = (P_DATA_HOLD == 0) ? S_WDATA : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = S_WDATA;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_WDATA: begin
                if (wr_ready) begin
                    // The bit-serial cursor runs across frames; only a new run rewinds it.
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        pix_d = pix_q + 8'd1;
                    end
                    if (beat_cnt_q == PIC_LAST) begin
                        beat_cnt_d = '0;
                        if (frame_idx_q != frames_q - 4'd1) begin
                            frame_idx_d = frame_idx_q + 4'd1;
                            state_d     = (P_DATA_HOLD == 0) ? S_WDATA : S_HOLD;
                        end else begin
                            state_d = S_STOP;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + AW'(1);
                    end
                end
            end
            S_STOP: begin
                frame_idx_d = 4'd0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from next-state values so that a stalled beat reproduces itself.
        wr_en_d   = (state_d == S_WDATA);
        wr_addr_d = wr_en_d ? P_START_ADDR + beat_cnt_d : '0;
        wr_data_d = wr_en_d ? pattern(mode_d, beat_cnt_d, frame_idx_d, pix_d, bit_d) : '0;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            frames_q    <= 4'd0;
            frame_idx_q <= 4'd0;
            beat_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            pix_q       <= 8'd0;
            bit_q       <= 3'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            frames_q    <= frames_d;
            frame_idx_q <= frame_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            pix_q       <= pix_d;
            bit_q       <= bit_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_idx = frame_idx_q;
endmodule
